// File: rtl/can_rx_frame_seq_if.sv
// Bit-stream, CRC-engine and frame-status signals of the CAN receive frame sequencer.
// The sequencer itself uses the slave view; the bus/engine side uses the master view.
interface can_rx_frame_seq_if;
    logic        bit_strobe;
    logic        rx_bit;
    logic        crc_clr;
    logic        crc_bit_valid;
    logic        crc_bit;
    logic [14:0] crc_in;
    logic [10:0] frame_id;
    logic        frame_rtr;
    logic [3:0]  frame_dlc;
    logic        rx_done;
    logic        crc_ok;
    logic        stuff_err;
    logic        form_err;
    logic        busy;

    modport master (
        output bit_strobe, rx_bit, crc_in,
        input  crc_clr, crc_bit_valid, crc_bit,
        input  frame_id, frame_rtr, frame_dlc,
        input  rx_done, crc_ok, stuff_err, form_err, busy
    );

    modport slave (
        input  bit_strobe, rx_bit, crc_in,
        output crc_clr, crc_bit_valid, crc_bit,
        output frame_id, frame_rtr, frame_dlc,
        output rx_done, crc_ok, stuff_err, form_err, busy
    );
endinterface

// File: rtl/can_rx_frame_seq.sv
// CAN 2.0A receive frame sequencer: destuffs the sampled bit stream, walks the frame
// fields from SOF to the CRC delimiter, feeds an external CRC-15 engine and reports status.
module can_rx_frame_seq #(
    parameter int IDLE_BITS     = 11,
    parameter int MAX_DLC_BYTES = 8
) (
    input logic               clk,
    input logic               rst_n,
    can_rx_frame_seq_if.slave bus
);

    localparam int                IDLE_W    = $clog2(IDLE_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);
    localparam logic [3:0]        DLC_CAP   = 4'(MAX_DLC_BYTES);

    typedef enum logic [2:0] {
        INTEG,
        IDLE,
        ARB,
        CTRL,
        DATA,
        CRC,
        CRC_DEL
    } state_t;

    state_t            state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [6:0]        bit_cnt, bit_cnt_nxt;
    logic [6:0]        data_bits, data_bits_nxt;
    logic              last_level, last_level_nxt;
    logic [2:0]        run_len, run_len_nxt;
    logic [10:0]       id_q, id_nxt;
    logic              rtr_q, rtr_nxt;
    logic [3:0]        dlc_q, dlc_nxt;
    logic [14:0]       rx_crc, rx_crc_nxt;
    logic [14:0]       calc_crc, calc_crc_nxt;
    logic              crc_ok_q, crc_ok_nxt;
    logic              stuff_err_q, stuff_err_nxt;
    logic              form_err_q, form_err_nxt;
    logic              busy_q, busy_nxt;
    logic              crc_clr_q, crc_clr_nxt;
    logic              crc_valid_q, crc_valid_nxt;
    logic              crc_bit_q, crc_bit_nxt;
    logic              rx_done_q, rx_done_nxt;

    logic              in_frame;
    logic              stuff_slot;
    logic              abort;
    logic [3:0]        dlc_new;
    logic [3:0]        dlc_bytes;
    logic [6:0]        n_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= INTEG;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            data_bits   <= '0;
            last_level  <= 1'b0;
            run_len     <= '0;
            id_q        <= '0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            rx_crc      <= '0;
            calc_crc    <= '0;
            crc_ok_q    <= 1'b0;
            stuff_err_q <= 1'b0;
            form_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            crc_clr_q   <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_bit_q   <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            data_bits   <= data_bits_nxt;
            last_level  <= last_level_nxt;
            run_len     <= run_len_nxt;
            id_q        <= id_nxt;
            rtr_q       <= rtr_nxt;
            dlc_q       <= dlc_nxt;
            rx_crc      <= rx_crc_nxt;
            calc_crc    <= calc_crc_nxt;
            crc_ok_q    <= crc_ok_nxt;
            stuff_err_q <= stuff_err_nxt;
            form_err_q  <= form_err_nxt;
            busy_q      <= busy_nxt;
            crc_clr_q   <= crc_clr_nxt;
            crc_valid_q <= crc_valid_nxt;
            crc_bit_q   <= crc_bit_nxt;
            rx_done_q   <= rx_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        idle_cnt_nxt   = idle_cnt;
        bit_cnt_nxt    = bit_cnt;
        data_bits_nxt  = data_bits;
        last_level_nxt = last_level;
        run_len_nxt    = run_len;
        id_nxt         = id_q;
        rtr_nxt        = rtr_q;
        dlc_nxt        = dlc_q;
        rx_crc_nxt     = rx_crc;
        calc_crc_nxt   = calc_crc;
        crc_ok_nxt     = crc_ok_q;
        stuff_err_nxt  = stuff_err_q;
        form_err_nxt   = form_err_q;
        busy_nxt       = busy_q;
        crc_clr_nxt    = 1'b0;
        crc_valid_nxt  = 1'b0;
        crc_bit_nxt    = 1'b0;
        rx_done_nxt    = 1'b0;
        abort          = 1'b0;

        dlc_new    = {dlc_q[2:0], bus.rx_bit};
        dlc_bytes  = (dlc_new > DLC_CAP) ? DLC_CAP : dlc_new;
        n_bits     = {dlc_bytes, 3'b000};
        in_frame   = (state == ARB) || (state == CTRL) || (state == DATA) || (state == CRC);
        stuff_slot = in_frame && (run_len == 3'd5);

        if (bus.bit_strobe) begin
            // The run tracker spans every destuffed field, including into the CRC field.
            if (in_frame) begin
                if (stuff_slot || (bus.rx_bit != last_level)) begin
                    last_level_nxt = bus.rx_bit;
                    run_len_nxt    = 3'd1;
                end else begin
                    run_len_nxt = run_len + 3'd1;
                end
            end

            // By the first CRC-field strobe the engine has absorbed the last data bit.
            if ((state == CRC) && (bit_cnt == 7'd0)) begin
                calc_crc_nxt = bus.crc_in;
            end

            if (stuff_slot) begin
                if (bus.rx_bit == last_level) begin
                    stuff_err_nxt = 1'b1;
                    abort         = 1'b1;
                end
            end else begin
                case (state)
                    INTEG: begin
                        if (bus.rx_bit) begin
                            if (idle_cnt == IDLE_LAST) begin
                                state_nxt = IDLE;
                            end
                            idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                        end else begin
                            idle_cnt_nxt = '0;
                        end
                    end
                    IDLE: begin
                        if (!bus.rx_bit) begin
                            state_nxt      = ARB;
                            bit_cnt_nxt    = '0;
                            last_level_nxt = 1'b0;
                            run_len_nxt    = 3'd1;
                            crc_clr_nxt    = 1'b1;
                            crc_valid_nxt  = 1'b1;
                            crc_bit_nxt    = 1'b0;
                            busy_nxt       = 1'b1;
                            crc_ok_nxt     = 1'b0;
                            stuff_err_nxt  = 1'b0;
                            form_err_nxt   = 1'b0;
                        end
                    end
                    ARB: begin
                        crc_valid_nxt = 1'b1;
                        crc_bit_nxt   = bus.rx_bit;
                        if (bit_cnt == 7'd11) begin
                            rtr_nxt     = bus.rx_bit;
                            bit_cnt_nxt = '0;
                            state_nxt   = CTRL;
                        end else begin
                            id_nxt      = {id_q[9:0], bus.rx_bit};
                            bit_cnt_nxt = bit_cnt + 7'd1;
                        end
                    end
                    CTRL: begin
                        crc_valid_nxt = 1'b1;
                        crc_bit_nxt   = bus.rx_bit;
                        bit_cnt_nxt   = bit_cnt + 7'd1;
                        if ((bit_cnt == 7'd0) && bus.rx_bit) begin
                            form_err_nxt = 1'b1;
                            abort        = 1'b1;
                        end else if (bit_cnt >= 7'd2) begin
                            dlc_nxt = dlc_new;
                        end
                        // Remote frames carry no data field regardless of DLC.
                        if (bit_cnt == 7'd5) begin
                            bit_cnt_nxt   = '0;
                            data_bits_nxt = rtr_q ? 7'd0 : n_bits;
                            state_nxt     = (rtr_q || (n_bits == 7'd0)) ? CRC : DATA;
                        end
                    end
                    DATA: begin
                        crc_valid_nxt = 1'b1;
                        crc_bit_nxt   = bus.rx_bit;
                        if (bit_cnt == (data_bits - 7'd1)) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = CRC;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 7'd1;
                        end
                    end
                    CRC: begin
                        rx_crc_nxt = {rx_crc[13:0], bus.rx_bit};
                        if (bit_cnt == 7'd14) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = CRC_DEL;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 7'd1;
                        end
                    end
                    CRC_DEL: begin
                        if (bus.rx_bit) begin
                            crc_ok_nxt   = (rx_crc == calc_crc);
                            rx_done_nxt  = 1'b1;
                            busy_nxt     = 1'b0;
                            idle_cnt_nxt = '0;
                            state_nxt    = INTEG;
                        end else begin
                            form_err_nxt = 1'b1;
                            abort        = 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = INTEG;
                    end
                endcase
            end

            if (abort) begin
                rx_done_nxt  = 1'b1;
                crc_ok_nxt   = 1'b0;
                busy_nxt     = 1'b0;
                idle_cnt_nxt = '0;
                state_nxt    = INTEG;
            end
        end
    end

    assign bus.crc_clr       = crc_clr_q;
    assign bus.crc_bit_valid = crc_valid_q;
    assign bus.crc_bit       = crc_bit_q;
    assign bus.frame_id      = id_q;
    assign bus.frame_rtr     = rtr_q;
    assign bus.frame_dlc     = dlc_q;
    assign bus.rx_done       = rx_done_q;
    assign bus.crc_ok        = crc_ok_q;
    assign bus.stuff_err     = stuff_err_q;
    assign bus.form_err      = form_err_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_can_rx_frame_seq.sv
// Scoreboard bench for can_rx_frame_seq: directed CAN frames are stuffed and driven bit by
// bit, a CRC-15 engine model answers crc_in, and a monitor checks each rx_done report.
module tb_can_rx_frame_seq;

    localparam int IDLE_BITS     = 11;
    localparam int MAX_DLC_BYTES = 8;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic [3:0]  dlc;
        logic        chk_id;
        logic        chk_dlc;
        logic        crc_ok;
        logic        stuff_err;
        logic        form_err;
        int          n_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   clr_cnt = 0;
    exp_t exp_q[$];
    bit   tx_q[$];
    logic [14:0] eng_crc;

    can_rx_frame_seq_if bus();

    can_rx_frame_seq #(
        .IDLE_BITS     (IDLE_BITS),
        .MAX_DLC_BYTES (MAX_DLC_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic [14:0] r;
        r = {c[13:0], 1'b0};
        if (b ^ c[14]) r = r ^ 15'h4599;
        return r;
    endfunction

    // CRC engine stand-in: a clear and the SOF shift arrive on the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) eng_crc <= '0;
        else if (bus.crc_clr) eng_crc <= bus.crc_bit_valid ? crc_step(15'd0, bus.crc_bit) : 15'd0;
        else if (bus.crc_bit_valid) eng_crc <= crc_step(eng_crc, bus.crc_bit);
    end
    assign bus.crc_in = eng_crc;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        bus.rx_bit     = b;
        bus.bit_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_strobe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic apply_stimulus(input int n_bits);
        for (int i = 0; i < n_bits && i < tx_q.size(); i++) send_bit(tx_q[i]);
    endtask

    // Raw frame bits with the reference CRC (optionally corrupted), then stuffed; the
    // delimiter follows the last CRC bit without a stuff bit in between.
    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                               input logic [3:0] dlc, input logic [63:0] data,
                               input int flip_bit, input logic delim);
        bit          raw_q[$];
        int          n;
        int          run;
        bit          last;
        logic [14:0] crc;
        tx_q.delete();
        raw_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
        raw_q.push_back(rtr);
        raw_q.push_back(ide);
        raw_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc)) * 8;
        for (int i = 0; i < n; i++) raw_q.push_back(data[63-i]);
        crc = '0;
        foreach (raw_q[i]) crc = crc_step(crc, raw_q[i]);
        if (flip_bit >= 0) crc[flip_bit] = ~crc[flip_bit];
        for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
        run  = 0;
        last = 1'b1;
        foreach (raw_q[i]) begin
            if (run == 5) begin
                last = !last;
                tx_q.push_back(last);
                run = 1;
            end
            tx_q.push_back(raw_q[i]);
            if (raw_q[i] == last) run++;
            else begin
                run  = 1;
                last = raw_q[i];
            end
        end
        tx_q.push_back(delim);
    endtask

    task automatic push_exp(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic chk_id, input logic chk_dlc, input logic ok,
                            input logic se, input logic fe, input int nv);
        exp_t e;
        e.id = id; e.rtr = rtr; e.dlc = dlc; e.chk_id = chk_id; e.chk_dlc = chk_dlc;
        e.crc_ok = ok; e.stuff_err = se; e.form_err = fe; e.n_valid = nv;
        exp_q.push_back(e);
    endtask

    task automatic wait_scoreboard(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check_output({name, "_done_seen"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_frame(input string name, input logic [10:0] id, input logic rtr,
                             input logic ide, input logic [3:0] dlc, input logic [63:0] data,
                             input int flip_bit, input logic delim);
        build_frame(id, rtr, ide, dlc, data, flip_bit, delim);
        send_idle(IDLE_BITS);
        apply_stimulus(tx_q.size());
        wait_scoreboard(name);
    endtask

    // Monitor: counts CRC-engine traffic per frame and checks each rx_done report.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            valid_cnt = 0;
            clr_cnt   = 0;
        end else begin
            if (bus.crc_clr) begin
                clr_cnt++;
                valid_cnt = 0;
            end
            if (bus.crc_bit_valid) valid_cnt++;
            if (bus.rx_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rx_done: got rx_done=1, expected no report");
                end else begin
                    e = exp_q.pop_front();
                    check_output("crc_ok", 32'(bus.crc_ok), 32'(e.crc_ok));
                    check_output("stuff_err", 32'(bus.stuff_err), 32'(e.stuff_err));
                    check_output("form_err", 32'(bus.form_err), 32'(e.form_err));
                    check_output("busy_at_done", 32'(bus.busy), 32'd0);
                    check_output("crc_valid_count", 32'(valid_cnt), 32'(e.n_valid));
                    check_output("crc_clr_count", 32'(clr_cnt), 32'd1);
                    if (e.chk_id) begin
                        check_output("frame_id", 32'(bus.frame_id), 32'(e.id));
                        check_output("frame_rtr", 32'(bus.frame_rtr), 32'(e.rtr));
                    end
                    if (e.chk_dlc) check_output("frame_dlc", 32'(bus.frame_dlc), 32'(e.dlc));
                end
                clr_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of run, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.bit_strobe = 1'b0;
        bus.rx_bit     = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_rx_done", 32'(bus.rx_done), 32'd0);
        check_output("reset_crc_ok", 32'(bus.crc_ok), 32'd0);
        check_output("reset_stuff_err", 32'(bus.stuff_err), 32'd0);
        check_output("reset_form_err", 32'(bus.form_err), 32'd0);
        check_output("reset_frame_id", 32'(bus.frame_id), 32'd0);
        check_output("reset_frame_rtr", 32'(bus.frame_rtr), 32'd0);
        check_output("reset_frame_dlc", 32'(bus.frame_dlc), 32'd0);
        check_output("reset_crc_clr", 32'(bus.crc_clr), 32'd0);
        check_output("reset_crc_valid", 32'(bus.crc_bit_valid), 32'd0);
        rst_n = 1'b1;

        // One recessive bit short of bus integration: this SOF must be ignored.
        send_idle(IDLE_BITS - 1);
        send_bit(1'b0);
        #1;
        check_output("early_sof_busy", 32'(bus.busy), 32'd0);

        push_exp(11'h123, 1'b0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27);
        run_frame("frame_0x123", 11'h123, 1'b0, 1'b0, 4'd1, {8'hA5, 56'h0}, -1, 1'b1);

        push_exp(11'h123, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 27);
        run_frame("bad_crc", 11'h123, 1'b0, 1'b0, 4'd1, {8'hA5, 56'h0}, 3, 1'b1);

        // SOF plus four ID zeros, then a zero where the stuff bit belongs.
        push_exp(11'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        send_idle(IDLE_BITS);
        repeat (6) send_bit(1'b0);
        wait_scoreboard("stuff_err");
        send_idle(5);
        send_bit(1'b0);
        #1;
        check_output("integ_after_abort_busy", 32'(bus.busy), 32'd0);

        push_exp(11'h5A3, 1'b1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19);
        run_frame("rtr_dlc8", 11'h5A3, 1'b1, 1'b0, 4'd8, 64'h0, -1, 1'b1);

        push_exp(11'h7F0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 83);
        run_frame("dlc15", 11'h7F0, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, 1'b1);

        push_exp(11'h2AA, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 35);
        run_frame("dominant_delim", 11'h2AA, 1'b0, 1'b0, 4'd2, {16'hBEEF, 48'h0}, -1, 1'b0);

        push_exp(11'h0F0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 14);
        run_frame("ide_set", 11'h0F0, 1'b0, 1'b1, 4'd0, 64'h0, -1, 1'b1);

        // Reset in the middle of the data field discards the partial frame.
        build_frame(11'h4D2, 1'b0, 1'b0, 4'd2, {16'hCAFE, 48'h0}, -1, 1'b1);
        send_idle(IDLE_BITS);
        apply_stimulus(26);
        #1;
        check_output("mid_frame_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset_mid_frame_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        push_exp(11'h3C5, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 35);
        run_frame("after_reset", 11'h3C5, 1'b0, 1'b0, 4'd2, {16'h1234, 48'h0}, -1, 1'b1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
